// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush controller for the 5-stage pipeline: cache-wait freeze with
// split-completion tracking, load-use bubble, mispredict flush, saturating counters.
module pipeline_hazard_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             imem_req,
  input  logic             imem_resp,
  input  logic             dmem_req,
  input  logic             dmem_resp,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_is_load,
  input  logic             ex_mispredict,
  output logic             load_pc,
  output logic             load_if_id,
  output logic             load_id_ex,
  output logic             load_ex_mem,
  output logic             load_mem_wb,
  output logic             flush_if_id,
  output logic             flush_id_ex,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  typedef enum logic [1:0] {RUN = 2'd0, HOLD_I = 2'd1, HOLD_D = 2'd2} state_t;

  state_t state, state_nxt;
  logic   i_wait, d_wait, freeze, load_use;

  // A hold state remembers which side already completed, so its wait term is masked.
  always_comb begin
    i_wait   = imem_req & ~imem_resp & (state != HOLD_I);
    d_wait   = dmem_req & ~dmem_resp & (state != HOLD_D);
    freeze   = i_wait | d_wait;
    load_use = ex_is_load & (ex_rd != 5'd0) &
               ((id_use_rs1 & (id_rs1 == ex_rd)) | (id_use_rs2 & (id_rs2 == ex_rd)));

    state_nxt = state;
    case (state)
      RUN: begin
        if (imem_req & imem_resp & d_wait)      state_nxt = HOLD_I;
        else if (dmem_req & dmem_resp & i_wait) state_nxt = HOLD_D;
      end
      HOLD_I:  if (dmem_resp) state_nxt = RUN;
      HOLD_D:  if (imem_resp) state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  // Reset gates the Mealy outputs directly so they drop without a clock edge.
  always_comb begin
    load_pc     = 1'b0;
    load_if_id  = 1'b0;
    load_id_ex  = 1'b0;
    load_ex_mem = 1'b0;
    load_mem_wb = 1'b0;
    flush_if_id = 1'b0;
    flush_id_ex = 1'b0;
    if (rst && !freeze) begin
      load_pc     = 1'b1;
      load_if_id  = 1'b1;
      load_id_ex  = 1'b1;
      load_ex_mem = 1'b1;
      load_mem_wb = 1'b1;
      if (ex_mispredict) begin
        flush_if_id = 1'b1;
        flush_id_ex = 1'b1;
      end else if (load_use) begin
        load_pc     = 1'b0;
        load_if_id  = 1'b0;
        flush_id_ex = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= RUN;
    else      state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      if (freeze && (stall_cycles != '1))
        stall_cycles <= stall_cycles + CNT_W'(1);
      if (!freeze && ex_mispredict && (flush_count != '1))
        flush_count <= flush_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed scenarios plus randomized traffic checked against a flag-based
// reference model of the stall/flush rules.
module tb_pipeline_hazard_ctrl;
  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic imem_req = 0, imem_resp = 0, dmem_req = 0, dmem_resp = 0;
  logic [4:0] id_rs1 = 0, id_rs2 = 0, ex_rd = 0;
  logic id_use_rs1 = 0, id_use_rs2 = 0, ex_is_load = 0, ex_mispredict = 0;
  logic load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb;
  logic flush_if_id, flush_id_ex;
  logic [CNT_W-1:0] stall_cycles, flush_count;

  pipeline_hazard_ctrl #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_resp(imem_resp),
    .dmem_req(dmem_req), .dmem_resp(dmem_resp),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_rd(ex_rd), .ex_is_load(ex_is_load), .ex_mispredict(ex_mispredict),
    .load_pc(load_pc), .load_if_id(load_if_id), .load_id_ex(load_id_ex),
    .load_ex_mem(load_ex_mem), .load_mem_wb(load_mem_wb),
    .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex),
    .stall_cycles(stall_cycles), .flush_count(flush_count)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // Reference model: "fetch done, waiting on data" / "data done, waiting on fetch".
  bit m_fetch_done, m_data_done;
  int m_stall, m_flush;

  wire [6:0] outs = {load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb,
                     flush_if_id, flush_id_ex};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit fetch_waiting();
    return imem_req && !imem_resp && !m_fetch_done;
  endfunction

  function automatic bit data_waiting();
    return dmem_req && !dmem_resp && !m_data_done;
  endfunction

  function automatic logic [6:0] exp_out();
    bit hazard;
    if (!rst || fetch_waiting() || data_waiting()) return 7'b0000000;
    if (ex_mispredict) return 7'b1111111;
    hazard = ex_is_load && ex_rd != 0 &&
             ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
    return hazard ? 7'b0011101 : 7'b1111100;
  endfunction

  task automatic model_step();
    bit fw, dw;
    fw = fetch_waiting();
    dw = data_waiting();
    if (fw || dw) begin
      if (m_stall < CNT_MAX) m_stall++;
    end else if (ex_mispredict) begin
      if (m_flush < CNT_MAX) m_flush++;
    end
    if (m_fetch_done) begin
      if (dmem_resp) m_fetch_done = 0;
    end else if (m_data_done) begin
      if (imem_resp) m_data_done = 0;
    end else if (imem_req && imem_resp && dw) begin
      m_fetch_done = 1;
    end else if (dmem_req && dmem_resp && fw) begin
      m_data_done = 1;
    end
  endtask

  // Called at a negedge with inputs already driven; returns at the next negedge.
  task automatic tick(input string tag);
    #1;
    if (m_fetch_done && imem_resp) chk({tag, "/proto_iresp"}, 1, 0);
    if (m_data_done && dmem_resp)  chk({tag, "/proto_dresp"}, 1, 0);
    chk({tag, "/outs"},  outs, exp_out());
    chk({tag, "/stall"}, stall_cycles, m_stall);
    chk({tag, "/flush"}, flush_count, m_flush);
    model_step();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    imem_req = 0; imem_resp = 0; dmem_req = 0; dmem_resp = 0;
    id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0;
    ex_rd = 0; ex_is_load = 0; ex_mispredict = 0;
  endtask

  // Asynchronous reset asserted between edges; effect checked before any clock edge.
  task automatic async_reset(input string tag);
    #3 rst = 0;
    #1;
    chk({tag, "/rst_outs"},  outs, 7'b0);
    chk({tag, "/rst_stall"}, stall_cycles, 0);
    chk({tag, "/rst_flush"}, flush_count, 0);
    m_fetch_done = 0; m_data_done = 0; m_stall = 0; m_flush = 0;
    @(negedge clk);
    @(negedge clk);
    rst = 1;
  endtask

  initial begin
    idle_inputs();
    m_fetch_done = 0; m_data_done = 0; m_stall = 0; m_flush = 0;
    @(negedge clk);
    #1;
    chk("reset/outs",  outs, 7'b0);
    chk("reset/stall", stall_cycles, 0);
    chk("reset/flush", flush_count, 0);
    @(negedge clk);
    rst = 1;

    // I-miss: frozen cycles 0-3, response on cycle 4
    imem_req = 1;
    for (int c = 0; c < 4; c++) begin
      tick("imiss_wait");
    end
    imem_resp = 1;
    #1 chk("imiss_resp_outs", outs, 7'b1111100);
    tick("imiss_resp");
    idle_inputs();
    chk("imiss_stall4", stall_cycles, 4);

    // Split completion: fetch done at cycle 2, data at cycle 6
    async_reset("split");
    imem_req = 1; dmem_req = 1;
    for (int c = 0; c < 7; c++) begin
      imem_resp = (c == 2);
      dmem_resp = (c == 6);
      if (c >= 3 && c <= 5) begin
        #1 chk("split_hold_frozen", outs, 7'b0);
      end
      if (c == 6) begin
        #1 chk("split_unfrozen", outs, 7'b1111100);
      end
      tick("split");
    end
    idle_inputs();
    chk("split_stall6", stall_cycles, 6);
    tick("split_after");

    // Load-use bubble for one cycle, then EX holds the bubble
    ex_is_load = 1; ex_rd = 5; id_rs2 = 5; id_use_rs2 = 1;
    #1 chk("loaduse_bubble", outs, 7'b0011101);
    tick("loaduse");
    ex_is_load = 0; ex_rd = 0;
    #1 chk("loaduse_cleared", outs, 7'b1111100);
    tick("loaduse_next");
    ex_is_load = 1; ex_rd = 0; id_rs2 = 0;
    #1 chk("loaduse_x0", outs, 7'b1111100);
    tick("loaduse_x0");

    // Mispredict together with load-use
    async_reset("misp_lu");
    ex_is_load = 1; ex_rd = 7; id_rs1 = 7; id_use_rs1 = 1; ex_mispredict = 1;
    #1 chk("misp_lu_outs", outs, 7'b1111111);
    tick("misp_lu");
    idle_inputs();
    chk("misp_lu_count", flush_count, 1);

    // Mispredict held through a 3-cycle D-miss
    async_reset("misp_dmiss");
    dmem_req = 1; ex_mispredict = 1;
    for (int c = 0; c < 3; c++) begin
      #1 chk("misp_dmiss_frozen", outs, 7'b0);
      tick("misp_dmiss");
    end
    dmem_resp = 1;
    #1 chk("misp_dmiss_apply", outs, 7'b1111111);
    tick("misp_dmiss_resp");
    idle_inputs();
    chk("misp_dmiss_count", flush_count, 1);
    chk("misp_dmiss_stall", stall_cycles, 3);

    // Saturation then asynchronous reset mid-freeze
    imem_req = 1;
    for (int c = 0; c < 20; c++) tick("sat");
    chk("sat_stall15", stall_cycles, 15);
    async_reset("sat");
    idle_inputs();
    tick("post_reset");

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 59) == 0) begin
        async_reset("rand");
      end
      imem_req      = ($urandom_range(0, 2) != 0);
      dmem_req      = ($urandom_range(0, 2) == 0);
      imem_resp     = imem_req && !m_fetch_done && ($urandom_range(0, 2) == 0);
      dmem_resp     = dmem_req && !m_data_done && ($urandom_range(0, 2) == 0);
      id_rs1        = 5'($urandom_range(0, 3));
      id_rs2        = 5'($urandom_range(0, 3));
      id_use_rs1    = 1'($urandom);
      id_use_rs2    = 1'($urandom);
      ex_rd         = 5'($urandom_range(0, 3));
      ex_is_load    = 1'($urandom);
      ex_mispredict = ($urandom_range(0, 5) == 0);
      tick("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end
endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Central stall/flush controller for the 5-stage pipeline. It drives the `load` enables of the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers, plus the bubble-insert (flush) selects for IF/ID and ID/EX. It resolves instruction- and data-cache waits, with independent completion tracking so a response pulse is never lost. It also handles load-use hazards and branch-mispredict redirects, and keeps saturating performance counters.

## Interface
Parameters:
- `CNT_W`, 32, width of the performance counters.

Ports:
- `clk`  in  1  system clock; all state updates on rising edge.
- `rst`  in  1  reset; asynchronous, active-low.
- `imem_req`  in  1  fetch outstanding; held high by IF until the PC advances.
- `imem_resp`  in  1  one-cycle I-cache completion pulse.
- `dmem_req`  in  1  MEM-stage load/store outstanding; held until EX/MEM advances.
- `dmem_resp`  in  1  one-cycle D-cache completion pulse.
- `id_rs1`, `id_rs2`  in  5  source registers of the instruction in ID.
- `id_use_rs1`, `id_use_rs2`  in  1  the ID instruction reads rs1/rs2.
- `ex_rd`  in  5  destination register of the instruction in EX.
- `ex_is_load`  in  1  the EX instruction is a load.
- `ex_mispredict`  in  1  EX resolved a branch/jump against its prediction.
- `load_pc`, `load_if_id`, `load_id_ex`, `load_ex_mem`, `load_mem_wb`  out  1  register load enables.
- `flush_if_id`, `flush_id_ex`  out  1  when high together with the matching load, the register captures an all-zero bubble.
- `stall_cycles`  out  CNT_W  count of frozen cycles.
- `flush_count`  out  CNT_W  count of mispredict flushes applied.

## Operation
- FSM states: RUN, HOLD_I (fetch already completed, data pending), HOLD_D (data already completed, fetch pending).
- Wait terms:
  - `i_wait = imem_req & ~imem_resp & (state != HOLD_I)`
  - `d_wait = dmem_req & ~dmem_resp & (state != HOLD_D)`
  - `freeze = i_wait | d_wait`
- Transitions:
  - RUN → HOLD_I when `imem_req & imem_resp & d_wait`.
  - RUN → HOLD_D when `dmem_req & dmem_resp & i_wait`.
  - Otherwise RUN stays in RUN.
  - HOLD_I → RUN on `dmem_resp`.
  - HOLD_D → RUN on `imem_resp`.
  - A hold state exits only on the pending side's response; the cycle of that response is unfrozen.
- Freeze: all five loads = 0, both flushes = 0. No hazard or mispredict action is taken.
- Mispredict (unfrozen, `ex_mispredict`): all loads = 1, `flush_if_id = flush_id_ex = 1`, `flush_count`++. Mispredict takes priority over load-use.
- Load-use (unfrozen, no mispredict): condition is `ex_is_load & ex_rd != 0 & ((id_use_rs1 & id_rs1 == ex_rd) | (id_use_rs2 & id_rs2 == ex_rd))`. Response:
  - `load_pc = load_if_id = 0`
  - `load_id_ex = 1`, `flush_id_ex = 1`
  - `load_ex_mem = load_mem_wb = 1`
- Normal (unfrozen, no hazard): all loads = 1, flushes = 0.
- A mispredict arriving during freeze stays stable (ID/EX is held) and is applied on the first unfrozen cycle.
- Counters saturate at all-ones and never wrap. `stall_cycles`++ on every frozen cycle.
- `imem_resp` in HOLD_I or `dmem_resp` in HOLD_D is a protocol violation. It is ignored for state purposes, and the bench flags it.

## Timing
- Load/flush outputs are combinational (Mealy) from inputs and state, with zero-cycle latency. Upstream register update occurs at the same clock edge.
- State and counters are registered and update on the rising edge.
- While `rst` = 0 (asynchronous):
  - state = RUN; `stall_cycles` = `flush_count` = 0.
  - All load and flush outputs are forced to 0.
- Deassertion of `rst` mid-wait discards hold state. The requester must re-issue after reset.
- Simultaneous `imem_resp` and `dmem_resp` in RUN: both complete, the FSM stays in RUN, and the cycle is unfrozen.
- Load-use bubble lasts exactly one cycle. On the next cycle EX holds the bubble, so the condition clears.

## Test plan
- I-miss only: `imem_req` = 1, `imem_resp` pulses on cycle 4 → loads = 0 for cycles 0–3, all loads = 1 on cycle 4, `stall_cycles` = 4.
- Split completion: both reqs high, `imem_resp` pulses at cycle 2, `dmem_resp` at cycle 6 → state HOLD_I during cycles 3–6, freeze through cycle 5, unfrozen at cycle 6, back to RUN at cycle 7, `stall_cycles` = 6.
- Load-use: `ex_is_load` = 1, `ex_rd` = 5, `id_rs2` = 5, `id_use_rs2` = 1 → `load_pc` = `load_if_id` = 0, `load_id_ex` = `flush_id_ex` = 1 for exactly one cycle. Repeat with `ex_rd` = 0 → no bubble.
- Mispredict plus load-use in the same cycle → both flushes = 1, all loads = 1, `flush_count` += 1.
- Mispredict during a 3-cycle D-miss → no flush for 3 cycles, flush on the `dmem_resp` cycle, `flush_count` = 1.
- Saturation and reset: with `CNT_W` = 4, hold a freeze for 20 cycles → `stall_cycles` = 15. Assert `rst` = 0 asynchronously mid-freeze → outputs and counters go to 0 immediately, without waiting for a clock edge.
